// File: rtl/pll_reset_sequencer_pkg.sv
// Shared state encoding, widths and counter sizing for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int RETRY_W = 2;
  localparam int LOSS_W  = 8;

  // Width of one counter able to reach the largest of three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the reference domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_r;

  // Metastability stage followed by the stable output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r   <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta_r   <= async_in;
      sync_out <= meta_r;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor running on the free-running reference clock.
// Define PLL_RESET_SEQUENCER_STATS_EN to implement the lock-loss counter.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               restart_req,
  output logic               pll_rst,
  output logic               core_reset_n,
  output logic               locked_stable,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  lock_loss_cnt
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  pll_state_e       state_r;
  logic [CNT_W-1:0] count_r;
  logic             locked_s;
  logic             armed_r;

  pll_lock_sync u_lock_sync (
    .clk      (clk_74a),
    .rst_n    (reset_n),
    .async_in (pll_locked),
    .sync_out (locked_s)
  );

  // The first edge after reset release only arms the sequencer
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= 1'b1;
    end
  end

  // Sequencer FSM: state, shared counter, retry count and registered outputs
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= RESET_PLL;
      count_r       <= {CNT_W{1'b0}};
      retry_cnt     <= {RETRY_W{1'b0}};
      pll_rst       <= 1'b1;
      core_reset_n  <= 1'b0;
      locked_stable <= 1'b0;
      fault         <= 1'b0;
    end else if (!armed_r) begin
      state_r <= state_r;
    end else if (restart_req) begin
      state_r       <= RESET_PLL;
      count_r       <= {CNT_W{1'b0}};
      retry_cnt     <= {RETRY_W{1'b0}};
      pll_rst       <= 1'b1;
      core_reset_n  <= 1'b0;
      locked_stable <= 1'b0;
      fault         <= 1'b0;
    end else begin
      case (state_r)
        RESET_PLL: begin
          if (count_r == RST_LAST) begin
            state_r <= WAIT_LOCK;
            count_r <= {CNT_W{1'b0}};
            pll_rst <= 1'b0;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_r <= STABLE;
            count_r <= {CNT_W{1'b0}};
          end else if (count_r == TIMEOUT_LAST) begin
            count_r <= {CNT_W{1'b0}};
            pll_rst <= 1'b1;
            if (retry_cnt == RETRY_MAX) begin
              state_r <= FAULT;
              fault   <= 1'b1;
            end else begin
              state_r   <= RESET_PLL;
              retry_cnt <= retry_cnt + RETRY_W'(1);
            end
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        STABLE: begin
          // A dropout restarts the lock wait without spending a retry
          if (!locked_s) begin
            state_r <= WAIT_LOCK;
            count_r <= {CNT_W{1'b0}};
          end else if (count_r == STABLE_LAST) begin
            state_r       <= RUN;
            count_r       <= {CNT_W{1'b0}};
            retry_cnt     <= {RETRY_W{1'b0}};
            core_reset_n  <= 1'b1;
            locked_stable <= 1'b1;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_r       <= RESET_PLL;
            count_r       <= {CNT_W{1'b0}};
            pll_rst       <= 1'b1;
            core_reset_n  <= 1'b0;
            locked_stable <= 1'b0;
          end else begin
            state_r <= RUN;
          end
        end
        FAULT: begin
          state_r <= FAULT;
        end
        default: begin
          state_r       <= RESET_PLL;
          count_r       <= {CNT_W{1'b0}};
          retry_cnt     <= {RETRY_W{1'b0}};
          pll_rst       <= 1'b1;
          core_reset_n  <= 1'b0;
          locked_stable <= 1'b0;
          fault         <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RESET_SEQUENCER_STATS_EN
  logic loss_event_s;

  // Counts whenever RUN sees lock drop, including when a restart wins the same edge
  assign loss_event_s = armed_r && (state_r == RUN) && !locked_s;

  // Saturating lock-loss counter, untouched by restart_req
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_cnt <= {LOSS_W{1'b0}};
    end else if (loss_event_s && (lock_loss_cnt != {LOSS_W{1'b1}})) begin
      lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
    end else begin
      lock_loss_cnt <= lock_loss_cnt;
    end
  end
`else
  assign lock_loss_cnt = {LOSS_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer (pulse 4, stable 8, timeout 32, retries 2).
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  logic       clk_74a = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       core_reset_n;
  logic       locked_stable;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] loss_exp = 8'd0;

  always #5 clk_74a = ~clk_74a;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2)
  ) dut (
    .clk_74a       (clk_74a),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .restart_req   (restart_req),
    .pll_rst       (pll_rst),
    .core_reset_n  (core_reset_n),
    .locked_stable (locked_stable),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_74a);
      #1;
    end
  endtask

  task automatic bump_loss();
`ifdef PLL_RESET_SEQUENCER_STATS_EN
    loss_exp = loss_exp + 8'd1;
`endif
  endtask

  // Reset values, then release with lock present: pulse edges 0-3, release at edge 13.
  task automatic test_reset_release();
    logic exp_rst;
    logic exp_run;
    reset_n = 1'b0; pll_locked = 1'b1; restart_req = 1'b0;
    step(3);
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL rst_pll_rst got %b want 1", pll_rst); end
    n_checks++; if (core_reset_n !== 1'b0) begin n_fail++; $display("FAIL rst_core_reset_n got %b want 0", core_reset_n); end
    n_checks++; if (locked_stable !== 1'b0) begin n_fail++; $display("FAIL rst_locked_stable got %b want 0", locked_stable); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got %b want 0", fault); end
    n_checks++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_retry_cnt got %0d want 0", retry_cnt); end
    n_checks++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_lock_loss_cnt got %0d want 0", lock_loss_cnt); end
    reset_n = 1'b1;
    for (int e = 0; e < 16; e++) begin
      step(1);
      exp_rst = (e <= 3);
      exp_run = (e >= 13);
      n_checks++; if (pll_rst !== exp_rst) begin n_fail++; $display("FAIL rel_pll_rst edge %0d got %b want %b", e, pll_rst, exp_rst); end
      n_checks++; if (core_reset_n !== exp_run) begin n_fail++; $display("FAIL rel_core_reset_n edge %0d got %b want %b", e, core_reset_n, exp_run); end
      n_checks++; if (locked_stable !== exp_run) begin n_fail++; $display("FAIL rel_locked_stable edge %0d got %b want %b", e, locked_stable, exp_run); end
    end
  endtask

  // One-cycle lock drop in RUN: core reset three edges later, fresh pulse, back to RUN.
  task automatic test_lock_loss();
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    n_checks++; if (core_reset_n !== 1'b1) begin n_fail++; $display("FAIL loss_e1_core got %b want 1", core_reset_n); end
    step(1);
    n_checks++; if (core_reset_n !== 1'b1) begin n_fail++; $display("FAIL loss_e2_core got %b want 1", core_reset_n); end
    step(1);
    bump_loss();
    n_checks++; if (core_reset_n !== 1'b0) begin n_fail++; $display("FAIL loss_e3_core got %b want 0", core_reset_n); end
    n_checks++; if (locked_stable !== 1'b0) begin n_fail++; $display("FAIL loss_e3_stable got %b want 0", locked_stable); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL loss_e3_pll_rst got %b want 1", pll_rst); end
    n_checks++; if (lock_loss_cnt !== loss_exp) begin n_fail++; $display("FAIL loss_cnt got %0d want %0d", lock_loss_cnt, loss_exp); end
    step(3);
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL loss_pulse_end got %b want 1", pll_rst); end
    step(1);
    n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL loss_pulse_low got %b want 0", pll_rst); end
    step(8);
    n_checks++; if (core_reset_n !== 1'b0) begin n_fail++; $display("FAIL loss_early_release got %b want 0", core_reset_n); end
    step(1);
    n_checks++; if (core_reset_n !== 1'b1) begin n_fail++; $display("FAIL loss_rerelease got %b want 1", core_reset_n); end
  endtask

  // Lock glitch at stable count 5 must force a full new debounce.
  task automatic test_stable_glitch();
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    n_checks++; if (core_reset_n !== 1'b0) begin n_fail++; $display("FAIL gl_restart_core got %b want 0", core_reset_n); end
    n_checks++; if (lock_loss_cnt !== loss_exp) begin n_fail++; $display("FAIL gl_restart_loss got %0d want %0d", lock_loss_cnt, loss_exp); end
    step(10);
    n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL gl_in_stable_pll_rst got %b want 0", pll_rst); end
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(2);
    n_checks++; if (core_reset_n !== 1'b0) begin n_fail++; $display("FAIL gl_no_release got %b want 0", core_reset_n); end
    n_checks++; if (locked_stable !== 1'b0) begin n_fail++; $display("FAIL gl_no_stable got %b want 0", locked_stable); end
    n_checks++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL gl_retry got %0d want 0", retry_cnt); end
    n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL gl_pll_rst got %b want 0", pll_rst); end
    step(8);
    n_checks++; if (core_reset_n !== 1'b0) begin n_fail++; $display("FAIL gl_early_release got %b want 0", core_reset_n); end
    step(1);
    n_checks++; if (core_reset_n !== 1'b1) begin n_fail++; $display("FAIL gl_release got %b want 1", core_reset_n); end
  endtask

  // restart_req on the same edge that RUN sees lock drop: one entry, one loss count.
  task automatic test_restart_lock_drop();
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    bump_loss();
    n_checks++; if (core_reset_n !== 1'b0) begin n_fail++; $display("FAIL rd_core got %b want 0", core_reset_n); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL rd_pll_rst got %b want 1", pll_rst); end
    n_checks++; if (lock_loss_cnt !== loss_exp) begin n_fail++; $display("FAIL rd_loss got %0d want %0d", lock_loss_cnt, loss_exp); end
    step(3);
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL rd_pulse_end got %b want 1", pll_rst); end
    step(1);
    n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_low got %b want 0", pll_rst); end
    step(9);
    n_checks++; if (core_reset_n !== 1'b1) begin n_fail++; $display("FAIL rd_release got %b want 1", core_reset_n); end
    n_checks++; if (lock_loss_cnt !== loss_exp) begin n_fail++; $display("FAIL rd_loss_once got %0d want %0d", lock_loss_cnt, loss_exp); end
  endtask

  // No lock: three pulses, retry_cnt 2, then FAULT; restart_req clears it.
  task automatic test_timeout_fault();
    int   rises;
    logic prev;
    pll_locked  = 1'b0;
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL to_first_pulse got %b want 1", pll_rst); end
    rises = 0;
    prev  = pll_rst;
    for (int i = 2; i <= 108; i++) begin
      step(1);
      if (pll_rst && !prev) rises++;
      prev = pll_rst;
      if (i == 40) begin
        n_checks++; if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL to_retry_mid got %0d want 1", retry_cnt); end
      end
    end
    n_checks++; if (rises !== 2) begin n_fail++; $display("FAIL to_retry_pulses got %0d want 2", rises); end
    n_checks++; if (retry_cnt !== 2'd2) begin n_fail++; $display("FAIL to_retry_cnt got %0d want 2", retry_cnt); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL to_early_fault got %b want 0", fault); end
    step(1);
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL to_fault got %b want 1", fault); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL to_fault_pll_rst got %b want 1", pll_rst); end
    n_checks++; if (retry_cnt !== 2'd2) begin n_fail++; $display("FAIL to_fault_retry got %0d want 2", retry_cnt); end
    step(20);
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL to_fault_hold got %b want 1", fault); end
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL to_restart_fault got %b want 0", fault); end
    n_checks++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL to_restart_retry got %0d want 0", retry_cnt); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL to_restart_pulse got %b want 1", pll_rst); end
    step(4);
    n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL to_restart_pulse_end got %b want 0", pll_rst); end
  endtask

  // reset_n mid-WAIT_LOCK returns every output to its reset value before the next edge.
  task automatic test_async_reset();
    step(36);
    step(2);
    n_checks++; if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL ar_pre_retry got %0d want 1", retry_cnt); end
    n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL ar_pre_pll_rst got %b want 0", pll_rst); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL ar_pll_rst got %b want 1", pll_rst); end
    n_checks++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL ar_retry got %0d want 0", retry_cnt); end
    n_checks++; if (core_reset_n !== 1'b0) begin n_fail++; $display("FAIL ar_core got %b want 0", core_reset_n); end
    n_checks++; if (locked_stable !== 1'b0) begin n_fail++; $display("FAIL ar_stable got %b want 0", locked_stable); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL ar_fault got %b want 0", fault); end
    n_checks++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL ar_loss got %0d want 0", lock_loss_cnt); end
    step(2);
    reset_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset_release();
    test_lock_loss();
    test_stable_glitch();
    test_restart_lock_drop();
    test_timeout_fault();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Supervises the core's clock-generation PLL: pulses its reset, waits for lock, debounces lock, then releases the core reset. It runs on the free-running 74.25 MHz reference clock because PLL outputs are not trusted before lock. It sits between the top level and the PLL wrapper, drives the PLL `rst`, consumes `locked`, and gates the core reset for all PLL-derived domains. It also handles lock-acquisition timeouts with bounded retries, lock loss during operation, and host-requested restarts.

Parameters:
- RST_PULSE_CYCLES, 16, number of clk_74a cycles `pll_rst` is held high per attempt (min 1).
- LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release (min 1).
- LOCK_TIMEOUT_CYCLES, 1048576, WAIT_LOCK cycles allowed before the attempt is declared failed.
- MAX_RETRIES, 3, number of timeout retries permitted before entering FAULT.

Ports:
- clk_74a, input, 1, 74.25 MHz reference clock; the only clock.
- reset_n, input, 1, asynchronous active-low reset.
- pll_locked, input, 1, PLL lock output; asynchronous, synchronised internally.
- restart_req, input, 1, single-cycle pulse that forces a full PLL restart.
- pll_rst, output, 1, PLL reset; active high.
- core_reset_n, output, 1, core reset for PLL-clocked logic; active low.
- locked_stable, output, 1, high only in RUN.
- fault, output, 1, high only in FAULT.
- retry_cnt, output, 2, number of timeout retries consumed in the current sequence.
- lock_loss_cnt, output, 8, saturating count of lock losses seen in RUN (see Optional Feature).

Behaviour:
- Interface: one clock, clk_74a; reset_n is asynchronous, active-low. All outputs are registered.
- Reset values: state RESET_PLL, pll_rst=1, core_reset_n=0, locked_stable=0, fault=0, retry_cnt=0, lock_loss_cnt=0, all counters 0.
- Synchronisation: `locked_s` is `pll_locked` passed through a 2-FF synchroniser, so it lags `pll_locked` by 2 cycles. Only `locked_s` is used in decisions.
- One shared counter, sized with $clog2 of the largest cycle parameter, is cleared on every state entry. Every transition takes one cycle.
- RESET_PLL:
  - pll_rst=1, core_reset_n=0.
  - When count == RST_PULSE_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Else, when count == LOCK_TIMEOUT_CYCLES-1:
    - if retry_cnt == MAX_RETRIES, go to FAULT;
    - otherwise retry_cnt++ and go to RESET_PLL.
- STABLE:
  - If locked_s=0, return to WAIT_LOCK. The timeout restarts and no retry is consumed.
  - When count == LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN.
- RUN:
  - core_reset_n=1, locked_stable=1, retry_cnt cleared on entry.
  - If locked_s=0, go to RESET_PLL. core_reset_n=0 and locked_stable=0 take effect on the same clock edge as the transition, i.e. 3 cycles after `pll_locked` falls.
  - lock_loss_cnt increments, saturating at 255.
- FAULT:
  - pll_rst=1, core_reset_n=0, fault=1.
  - Held until restart_req.
- restart_req:
  - Highest priority, in any state. Go to RESET_PLL, clear retry_cnt and fault, set core_reset_n=0.
  - In RESET_PLL it restarts the pulse count.
  - lock_loss_cnt is not cleared.
- Simultaneous lock loss and restart_req in RUN: the restart path is taken and lock_loss_cnt still increments.
- reset_n asserted mid-sequence: immediate asynchronous return to reset values, including pll_rst=1.
- Release latency with lock already present: core_reset_n rises RST_PULSE_CYCLES + 1 + LOCK_STABLE_CYCLES cycles after the first edge following reset release.

Optional Feature:
- Macro PLL_RESET_SEQUENCER_STATS_EN.
- Defined: lock_loss_cnt is implemented as specified above.
- Undefined: the counter logic is omitted and lock_loss_cnt is tied to 0. The port list is unchanged.

Decomposition:
- Package `pll_seq_pkg`:
  - state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT), 3 bits;
  - RETRY_W=2, LOSS_W=8;
  - width helper function for the counter.
- Sub-module `pll_lock_sync`: 2-FF synchroniser with async active-low reset, reset value 0.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. pll_locked tied to 1, release reset_n → pll_rst high for edges 0–3 and low from 4; core_reset_n and locked_stable rise at edge 13.
2. pll_locked tied to 0 → exactly 3 RESET_PLL pulses (initial + 2 retries), retry_cnt reaches 2, then fault=1 and pll_rst=1. A later restart_req clears fault and retry_cnt and starts a new pulse.
3. In RUN, drop pll_locked for 1 cycle → core_reset_n=0 three cycles later, pll_rst pulses, lock_loss_cnt=1. With the macro undefined, lock_loss_cnt stays 0.
4. In STABLE, glitch pll_locked low at stable count 5 → return to WAIT_LOCK, retry_cnt unchanged, full 8-cycle debounce required again.
5. restart_req during RUN, coincident with a lock drop → single RESET_PLL entry, lock_loss_cnt +1, core_reset_n low next cycle.
6. reset_n asserted mid-WAIT_LOCK → all outputs return to reset values asynchronously, before the next clk_74a edge.
